pingpong_frame_store: RTL and testbench

//  Parametrised double-buffered (ping-pong) pixel store with N arbitrated write channels and M read channels.

---
 rtl/pingpong_frame_store_if.sv | 29 ++
 rtl/pingpong_frame_store.sv | 181 ++++++++++++++++++
 tb/tb_pingpong_frame_store.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_frame_store_if.sv
// Bundle of the write, read and flip-handshake signals of pingpong_frame_store.
// master = pixel producers/consumers, slave = the frame store itself.
interface pingpong_frame_store_if #(
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 1,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 3
);
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        wr_grant;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     flip_req;
    logic                     flip_ack;
    logic                     front_sel;
    logic                     busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, flip_req,
        input  wr_grant, rd_data, flip_ack, front_sel, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, flip_req,
        output wr_grant, rd_data, flip_ack, front_sel, busy
    );
endinterface

// File: rtl/pingpong_frame_store.sv
// Double-buffered pixel store: round-robin writers fill the back buffer, readers see the front.
// Define AUTO_CLEAR_EN to clear the new back buffer to CLEAR_VAL on every flip.
module pingpong_frame_store #(
    parameter int                 NUM_WR    = 4,
    parameter int                 NUM_RD    = 1,
    parameter int                 ADDR_W    = 17,
    parameter int                 DATA_W    = 3,
    parameter int                 DEPTH     = 76800,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic                   clk,
    input  logic                   n_rst,
    pingpong_frame_store_if.slave  bus
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                PTR_W   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef AUTO_CLEAR_EN
        ST_CLEAR = 2'd1,
`endif
        ST_ACK   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     front_sel_q, front_sel_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
`ifdef AUTO_CLEAR_EN
    logic [IDX_W-1:0]         clr_cnt_q, clr_cnt_d;
`endif

    logic [DATA_W-1:0]        mem [2][DEPTH];

    logic                     grant_vld;
    logic [PTR_W-1:0]         grant_idx;
    logic [PTR_W-1:0]         cand;
    logic [NUM_WR-1:0]        grant_vec;
    logic [ADDR_W-1:0]        wr_addr_g;
    logic [DATA_W-1:0]        wr_data_g;
    logic [ADDR_W-1:0]        rd_addr_j;
    logic                     back_sel;
    logic                     mem_we;
    logic [IDX_W-1:0]         mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     flip_ack;

    assign back_sel = ~front_sel_q;

    // Round-robin search: first requester at or above rr_ptr_q, wrapping; only in IDLE.
    // NOTE: every variable of a combinational block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == ST_IDLE) begin
            for (int k = 0; k < NUM_WR; k++) begin
                cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_WR);
                if (!grant_vld && bus.wr_en[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_vld) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign wr_addr_g = bus.wr_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
    assign wr_data_g = bus.wr_data[int'(grant_idx) * DATA_W +: DATA_W];

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef AUTO_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        flip_ack    = 1'b0;

        // Out-of-range writes still consume their grant but never touch memory.
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_WR - 1)) ? '0 : grant_idx + 1'b1;
            if ({1'b0, wr_addr_g} < DEPTH_L) begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr_g[IDX_W-1:0];
                mem_wdata = wr_data_g;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.flip_req) begin
                    front_sel_d = ~front_sel_q;
`ifdef AUTO_CLEAR_EN
                    state_d     = ST_CLEAR;
                    clr_cnt_d   = '0;
`else
                    state_d     = ST_ACK;
`endif
                end
            end
`ifdef AUTO_CLEAR_EN
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = CLEAR_VAL;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_ACK;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
`endif
            ST_ACK: begin
                flip_ack = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        rd_addr_j = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_addr_j = bus.rd_addr[j * ADDR_W +: ADDR_W];
            if ({1'b0, rd_addr_j} < DEPTH_L) begin
                rd_data_d[j * DATA_W +: DATA_W] = mem[front_sel_q][rd_addr_j[IDX_W-1:0]];
            end else begin
                rd_data_d[j * DATA_W +: DATA_W] = CLEAR_VAL;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
            rr_ptr_q    <= '0;
            rd_data_q   <= '0;
`ifdef AUTO_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            rr_ptr_q    <= rr_ptr_d;
            rd_data_q   <= rd_data_d;
`ifdef AUTO_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

    // NOTE: the pixel arrays have no reset so they map onto plain RAM; contents survive n_rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[back_sel][mem_waddr] <= mem_wdata;
        end
    end

    assign bus.wr_grant  = grant_vec;
    assign bus.rd_data   = rd_data_q;
    assign bus.flip_ack  = flip_ack;
    assign bus.front_sel = front_sel_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pingpong_frame_store.sv
// Self-checking bench for pingpong_frame_store: vector table, directed corner cases and a
// randomized run against a buffer-level reference model. Honours AUTO_CLEAR_EN.
module tb_pingpong_frame_store;

    localparam int          NW    = 4;
    localparam int          NR    = 2;
    localparam int          AW    = 5;
    localparam int          DW    = 3;
    localparam int          DEP   = 16;
    localparam logic [2:0]  CLR_V = 3'd7;
`ifdef AUTO_CLEAR_EN
    localparam bit          CLR_EN = 1'b1;
`else
    localparam bit          CLR_EN = 1'b0;
`endif

    typedef struct {
        logic [NW-1:0] en;
        logic [NW-1:0] exp_grant;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    pingpong_frame_store_if #(.NUM_WR(NW), .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    pingpong_frame_store #(
        .NUM_WR(NW), .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .CLEAR_VAL(CLR_V)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // stimulus
    logic [NW-1:0] en;
    int            wa [NW];
    int            wd [NW];
    int            ra [NR];
    logic          flip;

    // observations of the last cycle
    logic [NW-1:0] obs_grant;
    logic          obs_ack, obs_front, obs_busy;
    logic [31:0]   obs_rd [NR];
    logic [NW-1:0] last_grant;

    // reference model: two whole buffers, a pointer, and a busy-cycle countdown
    int m_rr, m_front, m_busy;
    int m_mem [2][DEP];
    bit m_val [2][DEP];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.wr_en    = en;
        bus.flip_req = flip;
        for (int c = 0; c < NW; c++) begin
            bus.wr_addr[c*AW +: AW] = wa[c][AW-1:0];
            bus.wr_data[c*DW +: DW] = wd[c][DW-1:0];
        end
        for (int j = 0; j < NR; j++) bus.rd_addr[j*AW +: AW] = ra[j][AW-1:0];
    endtask

    // One clock: apply inputs, check combinational outputs, advance model, check read data.
    task automatic cycle();
        logic [NW-1:0] g;
        int            exp_rd [NR];
        bit            ok [NR];
        int            idx;
        drive();
        #1;
        g = '0;
        if (m_busy == 0) begin
            for (int k = 0; k < NW; k++) begin
                idx = (m_rr + k) % NW;
                if (en[idx] && g == '0) g[idx] = 1'b1;
            end
        end
        obs_grant = bus.wr_grant;
        obs_ack   = bus.flip_ack;
        obs_front = bus.front_sel;
        obs_busy  = bus.busy;
        check("grant", 32'(bus.wr_grant), 32'(g));
        check("busy", 32'(bus.busy), 32'(m_busy > 0));
        check("flip_ack", 32'(bus.flip_ack), 32'(m_busy == 1));
        check("front_sel", 32'(bus.front_sel), 32'(m_front));
        for (int j = 0; j < NR; j++) begin
            if (ra[j] >= DEP) begin
                exp_rd[j] = int'(CLR_V);
                ok[j]     = 1'b1;
            end else begin
                exp_rd[j] = m_mem[m_front][ra[j]];
                ok[j]     = m_val[m_front][ra[j]];
            end
        end
        for (int c = 0; c < NW; c++) begin
            if (g[c]) begin
                if (wa[c] < DEP) begin
                    m_mem[1-m_front][wa[c]] = wd[c];
                    m_val[1-m_front][wa[c]] = 1'b1;
                end
                m_rr = (c + 1) % NW;
            end
        end
        if (m_busy > 0) begin
            m_busy--;
        end else if (flip) begin
            m_front = 1 - m_front;
            m_busy  = CLR_EN ? DEP + 1 : 1;
            if (CLR_EN) begin
                for (int a = 0; a < DEP; a++) begin
                    m_mem[1-m_front][a] = int'(CLR_V);
                    m_val[1-m_front][a] = 1'b1;
                end
            end
        end
        last_grant = g;
        @(posedge clk);
        #1;
        for (int j = 0; j < NR; j++) begin
            obs_rd[j] = 32'(bus.rd_data[j*DW +: DW]);
            if (ok[j]) check("rd_data", obs_rd[j], 32'(exp_rd[j]));
        end
    endtask

    task automatic wait_idle(output int acks, output int busy_cycles);
        acks        = 0;
        busy_cycles = 0;
        for (int i = 0; i < 4 * DEP + 8 && m_busy > 0; i++) begin
            cycle();
            if (obs_ack)  acks++;
            if (obs_busy) busy_cycles++;
        end
        check("flip_timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic do_reset();
        en   = '0;
        flip = 1'b0;
        drive();
        #1;
        n_rst = 1'b0;
        #1;
        check("rst_grant", 32'(bus.wr_grant), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_flip_ack", 32'(bus.flip_ack), 32'd0);
        check("rst_front_sel", 32'(bus.front_sel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        if (CLR_EN && m_busy > 0) begin
            for (int a = 0; a < DEP; a++) m_val[1-m_front][a] = 1'b0;
        end
        m_rr    = 0;
        m_front = 0;
        m_busy  = 0;
        @(posedge clk);
        #2;
        n_rst = 1'b1;
    endtask

    vec_t tbl [9];
    bit   pend [NW];
    int   acks, bcyc;

    initial begin
        tbl[0] = '{4'b1111, 4'b0001};
        tbl[1] = '{4'b1110, 4'b0010};
        tbl[2] = '{4'b1100, 4'b0100};
        tbl[3] = '{4'b1000, 4'b1000};
        tbl[4] = '{4'b0100, 4'b0100};
        tbl[5] = '{4'b1001, 4'b1000};
        tbl[6] = '{4'b1001, 4'b0001};
        tbl[7] = '{4'b1001, 4'b1000};
        tbl[8] = '{4'b1001, 4'b0001};

        en = '0; flip = 1'b0; n_rst = 1'b1;
        for (int c = 0; c < NW; c++) begin wa[c] = c; wd[c] = c + 1; pend[c] = 1'b0; end
        for (int j = 0; j < NR; j++) ra[j] = 0;
        for (int a = 0; a < DEP; a++) begin m_val[0][a] = 1'b0; m_val[1][a] = 1'b0; end
        m_rr = 0; m_front = 0; m_busy = 0;
        drive();
        #2;
        do_reset();

        // arbitration vectors: all four requesting, then 3 and 0 competing from rr_ptr=3
        for (int i = 0; i < 9; i++) begin
            en = tbl[i].en;
            cycle();
            check($sformatf("tbl_grant[%0d]", i), 32'(obs_grant), 32'(tbl[i].exp_grant));
        end
        en = '0;

        flip = 1'b1;
        cycle();
        flip = 1'b0;
        wait_idle(acks, bcyc);
        check("t1_ack_once", 32'(acks), 32'd1);
        ra[0] = 2; ra[1] = 0;
        cycle();
        check("t1_rd_addr2", obs_rd[0], 32'd3);
        check("t1_rd_addr0", obs_rd[1], 32'd1);

        // write and flip in the same cycle
        en = 4'b0010; wa[1] = 5; wd[1] = 6; flip = 1'b1;
        cycle();
        check("t3_grant", 32'(obs_grant), 32'b0010);
        en = '0; flip = 1'b0; ra[0] = 5;
        cycle();
        check("t3_front_sel", 32'(obs_front), 32'd0);
        check("t3_rd", obs_rd[0], 32'd6);
        wait_idle(acks, bcyc);

        // out-of-range write and read
        en = 4'b0100; wa[2] = DEP; wd[2] = 5;
        cycle();
        check("t6_grant", 32'(obs_grant), 32'b0100);
        en = '0; flip = 1'b1;
        cycle();
        flip = 1'b0;
        wait_idle(acks, bcyc);
        ra[0] = 0; ra[1] = DEP + 3;
        cycle();
        check("t6_no_wrap", obs_rd[0], CLR_EN ? 32'd7 : 32'd1);
        check("t6_rd_oob", obs_rd[1], 32'(CLR_V));

`ifdef AUTO_CLEAR_EN
        // clear sequence: writers blocked while busy, then a full buffer of CLEAR_VAL
        for (int c = 0; c < NW; c++) begin wa[c] = c + 8; wd[c] = c; end
        flip = 1'b1;
        cycle();
        flip = 1'b0; en = 4'b1111;
        acks = 0; bcyc = 0;
        for (int i = 0; i < DEP; i++) begin
            cycle();
            check("t4_no_grant", 32'(obs_grant), 32'd0);
            if (obs_ack)  acks++;
            if (obs_busy) bcyc++;
        end
        en = '0;
        begin
            int a2, b2;
            wait_idle(a2, b2);
            acks += a2;
            bcyc += b2;
        end
        check("t4_busy_cycles", 32'(bcyc), 32'(DEP + 1));
        check("t4_ack_once", 32'(acks), 32'd1);
        flip = 1'b1;
        cycle();
        flip = 1'b0;
        wait_idle(acks, bcyc);
        for (int a = 0; a < DEP; a += NR) begin
            for (int j = 0; j < NR; j++) ra[j] = a + j;
            cycle();
            for (int j = 0; j < NR; j++) check($sformatf("t4_clear[%0d]", a + j), obs_rd[j], 32'(CLR_V));
        end
`endif

        // reset in the middle of a flip, then a write right after release
        flip = 1'b1;
        cycle();
        flip = 1'b0;
        for (int i = 0; i < (CLR_EN ? 8 : 0); i++) cycle();
        do_reset();
        en = 4'b1000; wa[3] = 1; wd[3] = 2;
        cycle();
        check("t5_grant_after_rst", 32'(obs_grant), 32'b1000);
        en = '0;

        // randomized traffic against the model
        for (int c = 0; c < NW; c++) pend[c] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NW; c++) begin
                if (!pend[c] && $urandom_range(2) == 0) begin
                    pend[c] = 1'b1;
                    wa[c]   = int'($urandom_range(DEP + 1));
                    wd[c]   = int'($urandom_range(7));
                end
                en[c] = pend[c];
            end
            for (int j = 0; j < NR; j++) ra[j] = int'($urandom_range(DEP + 3));
            flip = ($urandom_range(9) == 0);
            cycle();
            for (int c = 0; c < NW; c++) if (last_grant[c]) pend[c] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
